// File: rtl/io_output.sv
// io_output: four-phase CPU write port that loads a byte FIFO.
// A valid/ready sink drains the FIFO and a wrapping counter tracks delivered bytes.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif
`ifndef IO_STATE_BITS
`define IO_STATE_BITS 2
`endif
`ifndef IO_WAITREQ
`define IO_WAITREQ 2'd0
`endif
`ifndef IO_DOWORK
`define IO_DOWORK 2'd1
`endif
`ifndef IO_WAITACK
`define IO_WAITACK 2'd2
`endif

module io_output #(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   areset,
   input  logic                   req,
   output logic                   ack,
   input  logic [`WORD_SIZE-1:0]  data,
   output logic                   tx_valid,
   input  logic                   tx_ready,
   output logic [7:0]             tx_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic [15:0]            bytes_out
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [`IO_STATE_BITS-1:0] {
      WAITREQ = `IO_WAITREQ,
      DOWORK  = `IO_DOWORK,
      WAITACK = `IO_WAITACK
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [15:0]     bytes_out_q, bytes_out_d;
   logic [7:0]      mem [DEPTH];
   logic            push;
   logic            pop;
   logic            unused_data_hi;

   // Only the low byte of the CPU word is carried into the FIFO.
   assign unused_data_hi = ^data[`WORD_SIZE-1:8];

   assign full      = (count_q == CW'(DEPTH));
   assign tx_valid  = (count_q != '0);
   assign tx_data   = mem[rd_ptr_q];
   assign count     = count_q;
   assign bytes_out = bytes_out_q;
   assign ack       = (state_q == WAITACK);

   // Full is judged on the registered count, so a same-edge pop cannot unblock a push.
   assign push = (state_q == DOWORK) && !full;
   assign pop  = tx_valid && tx_ready;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         WAITREQ: if (req)   state_d = DOWORK;
         DOWORK:  if (!full) state_d = WAITACK;
         WAITACK: if (!req)  state_d = WAITREQ;
         default:            state_d = WAITREQ;
      endcase
   end

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      bytes_out_d = bytes_out_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop) begin
         rd_ptr_d    = rd_ptr_q + PW'(1);
         bytes_out_d = bytes_out_q + 16'd1;
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q     <= WAITREQ;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         bytes_out_q <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         bytes_out_q <= bytes_out_d;
      end
   end

   // Storage is deliberately left out of reset; it is never observed while empty.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= data[7:0];
   end

endmodule

// File: tb/tb_io_output.sv
// Randomized scoreboard bench for io_output: stimulus queues expected bytes,
// a negedge monitor checks every delivered byte and the running byte counter.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module tb_io_output;
   localparam int DEPTH = 4;
   localparam int WS    = `WORD_SIZE;

   logic          clk = 1'b0;
   logic          areset;
   logic          req;
   logic          ack;
   logic [WS-1:0] data;
   logic          tx_valid;
   logic          tx_ready;
   logic [7:0]    tx_data;
   logic [2:0]    count;
   logic          full;
   logic [15:0]   bytes_out;

   int            checks = 0;
   int            errors = 0;
   logic [7:0]    exp_q[$];
   logic [15:0]   model_bytes = 16'd0;
   bit            mon_en = 1'b0;
   bit            rnd_ready = 1'b0;

   io_output #(.DEPTH(DEPTH)) dut (
      .clk(clk), .areset(areset), .req(req), .ack(ack), .data(data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
      .count(count), .full(full), .bytes_out(bytes_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every sink transfer must deliver the oldest outstanding byte.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en && !areset) begin
            chk("bytes_out", 32'(bytes_out), 32'(model_bytes));
            if (tx_valid && tx_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL pop_unexpected: got %0h expected no byte", tx_data);
               end else begin
                  chk("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
               end
               model_bytes = model_bytes + 16'd1;
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd_ready) tx_ready = 1'($urandom);
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req_start(input logic [7:0] b);
      data      = WS'($urandom);
      data[7:0] = b;
      req       = 1'b1;
      exp_q.push_back(b);
   endtask

   task automatic wait_ack(input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         tick();
         if (ack) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic req_end();
      req  = 1'b0;
      data = WS'($urandom);
      tick();
      chk("ack_drop", 32'(ack), 32'd0);
   endtask

   task automatic cpu_write(input logic [7:0] b);
      bit ok;
      req_start(b);
      wait_ack(100, ok);
      chk("write_ack", 32'(ok), 32'd1);
      req_end();
   endtask

   task automatic drain();
      tx_ready = 1'b1;
      for (int i = 0; i < 64 && tx_valid; i++) tick();
      chk("drain_empty", 32'(tx_valid), 32'd0);
      tx_ready = 1'b0;
   endtask

   // Called just after an edge; the pulse sits wholly between two edges.
   task automatic pulse_reset();
      #1;
      areset = 1'b1;
      exp_q.delete();
      model_bytes = 16'd0;
      #1;
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_bytes_out", 32'(bytes_out), 32'd0);
      #1;
      areset = 1'b0;
      tick();
   endtask

   initial begin
      logic [7:0]  held;
      logic [15:0] b0;
      bit          ok;

      areset   = 1'b1;
      req      = 1'b0;
      tx_ready = 1'b0;
      data     = '0;
      #12;
      chk("init_ack", 32'(ack), 32'd0);
      chk("init_tx_valid", 32'(tx_valid), 32'd0);
      chk("init_full", 32'(full), 32'd0);
      chk("init_count", 32'(count), 32'd0);
      chk("init_bytes_out", 32'(bytes_out), 32'd0);
      areset = 1'b0;
      mon_en = 1'b1;
      tick();

      // single write, two-edge ack latency
      req  = 1'b1;
      data = WS'(16'h0041);
      exp_q.push_back(8'h41);
      tick();
      chk("single_ack_e1", 32'(ack), 32'd0);
      tick();
      chk("single_ack_e2", 32'(ack), 32'd1);
      chk("single_tx_valid", 32'(tx_valid), 32'd1);
      chk("single_tx_data", 32'(tx_data), 32'h41);
      chk("single_count", 32'(count), 32'd1);
      req_end();
      drain();

      // full stall
      for (int i = 1; i <= 4; i++) cpu_write(8'(i));
      chk("stall_full", 32'(full), 32'd1);
      chk("stall_count", 32'(count), 32'd4);
      req_start(8'h05);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("stall_ack", 32'(ack), 32'd0);
         chk("stall_count_hold", 32'(count), 32'd4);
      end
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      chk("stall_pop_count", 32'(count), 32'd3);
      chk("stall_pop_ack", 32'(ack), 32'd0);
      tick();
      chk("stall_done_ack", 32'(ack), 32'd1);
      chk("stall_done_count", 32'(count), 32'd4);
      req_end();
      drain();

      // ordering and drain from a clean counter
      pulse_reset();
      cpu_write(8'hAA);
      cpu_write(8'hBB);
      cpu_write(8'hCC);
      drain();
      chk("order_bytes_out", 32'(bytes_out), 32'd3);
      chk("order_tx_valid", 32'(tx_valid), 32'd0);

      // simultaneous push and pop
      cpu_write(8'($urandom));
      cpu_write(8'($urandom));
      chk("simul_pre_count", 32'(count), 32'd2);
      req_start(8'($urandom));
      tick();
      tx_ready = 1'b1;
      b0 = bytes_out;
      tick();
      tx_ready = 1'b0;
      chk("simul_count", 32'(count), 32'd2);
      chk("simul_bytes_out", 32'(bytes_out), 32'(b0 + 16'd1));
      chk("simul_ack", 32'(ack), 32'd1);
      req_end();

      // reset mid-handshake, req kept high so the write repeats
      held = 8'($urandom);
      req_start(held);
      wait_ack(20, ok);
      chk("mid_ack", 32'(ok), 32'd1);
      chk("mid_count", 32'(count), 32'd3);
      pulse_reset();
      exp_q.push_back(held);
      tick();
      chk("dup_ack", 32'(ack), 32'd1);
      chk("dup_count", 32'(count), 32'd1);
      chk("dup_tx_data", 32'(tx_data), 32'(held));
      req_end();
      drain();

      // randomized traffic with random sink backpressure
      rnd_ready = 1'b1;
      for (int i = 0; i < 40; i++) cpu_write(8'($urandom));
      rnd_ready = 1'b0;
      tx_ready  = 1'b0;
      drain();

      // counter wrap: preload stands in for the first 65534 pops
      force dut.bytes_out_q = 16'hFFFE;
      model_bytes = 16'hFFFE;
      #1;
      release dut.bytes_out_q;
      tick();
      cpu_write(8'h11);
      cpu_write(8'h22);
      cpu_write(8'h33);
      drain();
      chk("wrap_bytes_out", 32'(bytes_out), 32'h0001);

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/io_output.md
IO_OUTPUT -- requirements
Module: io_output

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning byte FIFO depth; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL take its data width from `WORD_SIZE in defines.vh, and its state width and encodings from `IO_STATE_BITS, `IO_WAITREQ, `IO_DOWORK and `IO_WAITACK.
REQ-003 The block SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port areset  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port req  input  1  CPU write request, four-phase.
REQ-006 The block SHALL have port ack  output  1  write acknowledge, four-phase.
REQ-007 The block SHALL have port data  input  `WORD_SIZE  CPU write word; only bits [7:0] are used.
REQ-008 The block SHALL have port tx_valid  output  1  the FIFO head byte is available.
REQ-009 The block SHALL have port tx_ready  input  1  the downstream sink accepts the head byte.
REQ-010 The block SHALL have port tx_data  output  8  the FIFO head byte.
REQ-011 The block SHALL have port count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 The block SHALL have port full  output  1  high when count == DEPTH.
REQ-013 The block SHALL have port bytes_out  output  16  total bytes popped, wrapping modulo 2^16.

Function
REQ-014 The handshake FSM SHALL use exactly three states: WAITREQ, DOWORK and WAITACK.
REQ-015 The FSM SHALL move from WAITREQ to DOWORK on a clock edge when req=1.
REQ-016 In DOWORK with full=0, the FSM SHALL push data[7:0] into the FIFO and move to WAITACK on the same edge.
REQ-017 In DOWORK with full=1, the FSM SHALL stay in DOWORK and push nothing.
REQ-018 Full SHALL be evaluated on the pre-edge count; a pop on the same edge does not free a slot until the next cycle.
REQ-019 The FSM SHALL move from WAITACK to WAITREQ on a clock edge when req=0.
REQ-020 ack SHALL be combinational and equal to (state == WAITACK).
REQ-021 The block SHALL sample data only in DOWORK; data changes in any other state SHALL have no effect.
REQ-022 tx_valid SHALL equal (count != 0), and tx_data SHALL be the byte at the read pointer, both combinational from registers.
REQ-023 A pop SHALL occur on a clock edge when tx_valid=1 and tx_ready=1; a pop advances the read pointer and increments bytes_out.
REQ-024 bytes_out SHALL wrap from 16'hFFFF to 16'h0000.
REQ-025 tx_ready=1 while count=0 SHALL have no effect.
REQ-026 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-027 Read and write pointers SHALL be $clog2(DEPTH) bits wide and wrap naturally.
REQ-028 FIFO order SHALL be strict first-in first-out.
REQ-029 The minimum latency from a CPU push to tx_valid SHALL be one cycle, with tx_valid high in the cycle after the DOWORK edge.
REQ-030 The minimum request-to-ack latency SHALL be two edges, with no backpressure.

Reset
REQ-031 On areset=1, state SHALL become WAITREQ immediately, without waiting for a clock edge.
REQ-032 On areset=1, pointers, count and bytes_out SHALL become 0, so that ack=0, tx_valid=0, full=0 and count=0.
REQ-033 FIFO storage contents SHALL NOT be reset; the contents are don't-care while count=0.
REQ-034 Reset mid-handshake SHALL drop ack at once.
REQ-035 After release, a req still held high SHALL start a new transaction, i.e. a duplicate write; the CPU side is responsible for handling this.
REQ-036 The block SHALL leave reset on the first clock edge after areset falls.

Verification
REQ-037 The bench SHALL cover single write: req=1 with data=16'h0041, tx_ready=0 -> ack=1 two edges later; tx_valid=1 and tx_data=8'h41; count=1; after req=0, ack=0 on the next edge.
REQ-038 The bench SHALL cover the full stall: 4 writes of 8'h01..8'h04 with tx_ready=0 -> full=1, count=4; a 5th write with 8'h05 holds in DOWORK with ack=0; raising tx_ready for 1 cycle pops 8'h01; the 5th write then completes and count=4.
REQ-039 The bench SHALL cover ordering and drain: writes 8'hAA, 8'hBB, 8'hCC followed by tx_ready=1 continuous -> tx_data sequence AA, BB, CC; bytes_out=3; tx_valid=0 afterwards.
REQ-040 The bench SHALL cover simultaneous push and pop: count=2 with tx_ready=1 while DOWORK pushes -> count stays 2 across that edge; bytes_out +1.
REQ-041 The bench SHALL cover reset mid-operation: count=3, state WAITACK, areset pulsed between edges -> ack=0, tx_valid=0, count=0 before the next edge; bytes_out=0.
REQ-042 The bench SHALL cover counter wrap: preload via 65537 pops -> bytes_out=16'h0001.
